// File: rtl/wbs_pkg.sv
// Shared types and widths for the word-to-byte sequencer.
package wbs_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned WORD_W     = BYTE_W * WORD_BYTES;
    localparam int unsigned GAP_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/word_byte_sequencer_splitter.sv
// Combinational splitter: breaks a 32-bit word into its four bytes, O1 = most significant.
module word_byte_sequencer_splitter
    import wbs_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    output logic [BYTE_W-1:0] o1,
    output logic [BYTE_W-1:0] o2,
    output logic [BYTE_W-1:0] o3,
    output logic [BYTE_W-1:0] o4
);

    assign o1 = a[31:24];
    assign o2 = a[23:16];
    assign o3 = a[15:8];
    assign o4 = a[7:0];

endmodule

// File: rtl/word_byte_sequencer.sv
// Accepts a 32-bit word by valid/ready and emits its four bytes on a byte stream.
// Optional out_last port enabled by defining WBS_LAST_EN.
module word_byte_sequencer
    import wbs_pkg::*;
#(
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_byte,
    output logic [IDX_W-1:0]  out_idx,
`ifdef WBS_LAST_EN
    output logic              out_last,
`endif
    output logic              busy
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                out_valid_q, out_valid_d;
    logic [BYTE_W-1:0]   out_byte_q, out_byte_d;
    logic [IDX_W-1:0]    out_idx_q, out_idx_d;
    logic                busy_q, busy_d;
    logic                in_ready_q, in_ready_d;
    logic [BYTE_W-1:0]   b1, b2, b3, b4;
    logic [BYTE_W-1:0]   sel_byte;

    // Splitter sees the word that will be held next cycle so out_byte can be registered.
    word_byte_sequencer_splitter u_splitter (
        .a  (word_d),
        .o1 (b1),
        .o2 (b2),
        .o3 (b3),
        .o4 (b4)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        word_d  = word_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d  = in_word;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (idx_q == IDX_W'(WORD_BYTES - 1)) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else if (GAP_CYCLES == 0) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        gap_d   = GAP_W'(GAP_CYCLES - 1);
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = SEND;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequence index to splitter lane, reversed when emitting LSB first.
    always_comb begin
        sel_byte = '0;
        case (idx_d)
            2'd0:    sel_byte = MSB_FIRST ? b1 : b4;
            2'd1:    sel_byte = MSB_FIRST ? b2 : b3;
            2'd2:    sel_byte = MSB_FIRST ? b3 : b2;
            default: sel_byte = MSB_FIRST ? b4 : b1;
        endcase
    end

    always_comb begin
        out_valid_d = (state_d == SEND);
        busy_d      = (state_d != IDLE);
        in_ready_d  = (state_d == IDLE);
        out_idx_d   = idx_d;
        out_byte_d  = out_byte_q;
        if (state_d == SEND) begin
            out_byte_d = sel_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            gap_q       <= '0;
            word_q      <= '0;
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
            out_idx_q   <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            word_q      <= word_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            out_idx_q   <= out_idx_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_byte  = out_byte_q;
    assign out_idx   = out_idx_q;
    assign busy      = busy_q;
    assign in_ready  = in_ready_q;

`ifdef WBS_LAST_EN
    logic out_last_q, out_last_d;

    assign out_last_d = (state_d == SEND) && (idx_d == IDX_W'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_last_q <= 1'b0;
        end else begin
            out_last_q <= out_last_d;
        end
    end

    assign out_last = out_last_q;
`endif

endmodule

// File: tb/tb_word_byte_sequencer.sv
// Bench for word_byte_sequencer: three configurations driven side by side, checked
// against a byte-list / gap-count reference model.
module tb_word_byte_sequencer;

    localparam int NDUT = 3;

    logic        clk;
    logic        rst_n     [NDUT];
    logic        in_valid  [NDUT];
    logic        in_ready  [NDUT];
    logic [31:0] in_word   [NDUT];
    logic        out_valid [NDUT];
    logic        out_ready [NDUT];
    logic [7:0]  out_byte  [NDUT];
    logic [1:0]  out_idx   [NDUT];
    logic        busy      [NDUT];
    logic        out_last  [NDUT];

    int ntests = 0;
    int nfail  = 0;

    // Instance 0: MSB first, no gap. Instance 1: MSB first, gap 2. Instance 2: LSB first.
    word_byte_sequencer #(.MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_word(in_word[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_byte(out_byte[0]), .out_idx(out_idx[0]),
`ifdef WBS_LAST_EN
        .out_last(out_last[0]),
`endif
        .busy(busy[0]));

    word_byte_sequencer #(.MSB_FIRST(1'b1), .GAP_CYCLES(2)) u_dut1 (
        .clk(clk), .reset(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_word(in_word[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_byte(out_byte[1]), .out_idx(out_idx[1]),
`ifdef WBS_LAST_EN
        .out_last(out_last[1]),
`endif
        .busy(busy[1]));

    word_byte_sequencer #(.MSB_FIRST(1'b0), .GAP_CYCLES(0)) u_dut2 (
        .clk(clk), .reset(rst_n[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_word(in_word[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_byte(out_byte[2]), .out_idx(out_idx[2]),
`ifdef WBS_LAST_EN
        .out_last(out_last[2]),
`endif
        .busy(busy[2]));

`ifndef WBS_LAST_EN
    initial for (int k = 0; k < NDUT; k++) out_last[k] = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit msb_of(input int k);
        return (k != 2);
    endfunction

    function automatic int gap_of(input int k);
        return (k == 1) ? 2 : 0;
    endfunction

    // Expected emission order: n-th byte sent for word w.
    function automatic logic [7:0] exp_byte(input int k, input logic [31:0] w, input int n);
        int lane;
        lane = msb_of(k) ? (3 - n) : n;
        return 8'((w >> (8 * lane)) & 32'hff);
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s dut%0d: got %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int k);
        chk({tag, "_valid"}, k, 32'(out_valid[k]), 32'd0);
        chk({tag, "_busy"},  k, 32'(busy[k]),      32'd0);
        chk({tag, "_ready"}, k, 32'(in_ready[k]),  32'd1);
    endtask

    // Offer one word, then drain its bytes; called and returning on a negedge.
    // stall_pct: random out_ready=0 chance; stall_at/stall_len: forced stall at a byte index.
    task automatic run_word(input int k, input logic [31:0] w, input int stall_pct,
                            input int stall_at, input int stall_len, input bit spur);
        int  cnt, gap, cyc, stalled;
        bit  exp_v, rdy, hs;
        chk("pre_idle_ready", k, 32'(in_ready[k]), 32'd1);
        in_valid[k] = 1'b1;
        in_word[k]  = w;
        @(negedge clk);
        in_valid[k] = 1'b0;
        cnt = 0; gap = 0; cyc = 0; stalled = 0;
        while (cnt < 4 && cyc < 200) begin
            exp_v = (gap == 0);
            chk("out_valid", k, 32'(out_valid[k]), 32'(exp_v));
            chk("busy",      k, 32'(busy[k]),      32'd1);
            chk("in_ready",  k, 32'(in_ready[k]),  32'd0);
            if (exp_v) begin
                chk("out_byte", k, 32'(out_byte[k]), 32'(exp_byte(k, w, cnt)));
                chk("out_idx",  k, 32'(out_idx[k]),  32'(cnt));
`ifdef WBS_LAST_EN
                chk("out_last", k, 32'(out_last[k]), 32'(cnt == 3));
`endif
            end
            if (cnt == stall_at && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end else begin
                rdy = ($urandom_range(99) >= stall_pct);
            end
            out_ready[k] = rdy;
            in_valid[k]  = spur && ($urandom_range(3) == 0);
            in_word[k]   = 32'hdeadbeef;
            hs = exp_v && rdy;
            @(negedge clk);
            in_valid[k] = 1'b0;
            if (hs) begin
                cnt++;
                gap = (cnt < 4) ? gap_of(k) : 0;
            end else if (gap > 0) begin
                gap--;
            end
            cyc++;
        end
        chk("handshakes", k, 32'(cnt), 32'd4);
        chk_idle("post_word", k);
        out_ready[k] = 1'b1;
        @(negedge clk);
        chk("no_extra", k, 32'(out_valid[k]), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        for (int k = 0; k < NDUT; k++) begin
            rst_n[k] = 1'b0; in_valid[k] = 1'b0; in_word[k] = '0; out_ready[k] = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk_idle("reset", k);
            chk("reset_byte", k, 32'(out_byte[k]), 32'd0);
            chk("reset_idx",  k, 32'(out_idx[k]),  32'd0);
            chk("reset_last", k, 32'(out_last[k]), 32'd0);
            rst_n[k] = 1'b1;
        end
        @(negedge clk);

        // Basic MSB-first word, then a stall of 3 cycles at byte 1.
        run_word(0, 32'hffff0010, 0, -1, 0, 1'b0);
        run_word(0, 32'h0ff0f00f, 0, 1, 3, 1'b0);
        // Gap insertion and LSB-first order with ignored in_valid during SEND.
        run_word(1, 32'h12345678, 0, -1, 0, 1'b0);
        run_word(2, 32'hffff0000, 0, -1, 0, 1'b1);

        // Reset in the middle of a word at idx 2.
        in_valid[0] = 1'b1; in_word[0] = 32'ha1b2c3d4; out_ready[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_idx",  0, 32'(out_idx[0]),  32'd2);
        chk("pre_rst_byte", 0, 32'(out_byte[0]), 32'hc3);
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        chk_idle("mid_reset", 0);
        chk("mid_reset_byte", 0, 32'(out_byte[0]), 32'd0);
        chk("mid_reset_idx",  0, 32'(out_idx[0]),  32'd0);
        @(negedge clk);
        chk("mid_reset_quiet", 0, 32'(out_valid[0]), 32'd0);
        run_word(0, 32'h5a6b7c8d, 0, -1, 0, 1'b0);

        // Randomized words with random backpressure and stray in_valid pulses.
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < NDUT; k++) begin
                w = $urandom;
                run_word(k, w, 35, int'($urandom_range(3)), int'($urandom_range(4)), 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
